// File: rtl/tensor_wb_queue.sv
// In-order writeback FIFO between the tensor core and the commit/writeback arbiter,
// with per-warp tile row tracking. Optional macro: TENSOR_WBQ_BYPASS_EN (empty-queue bypass).
module tensor_wb_queue #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NUM_WARPS   = 8,
  parameter int THREAD_N    = 4,
  parameter int DEPTH       = 4,
  parameter int NR_BITS     = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_THREADS*XLEN-1:0]   in_data,
  input  logic [NR_BITS-1:0]            in_rd,
  input  logic [$clog2(NUM_WARPS)-1:0]  in_wid,
  input  logic                          in_wb,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_THREADS*XLEN-1:0]   out_data,
  output logic [NR_BITS-1:0]            out_rd,
  output logic [$clog2(NUM_WARPS)-1:0]  out_wid,
  output logic                          out_wb,
  output logic                          out_last,
  output logic                          tile_done_valid,
  output logic [$clog2(NUM_WARPS)-1:0]  tile_done_wid,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);
  localparam int DW = NUM_THREADS * XLEN;
  localparam int WW = $clog2(NUM_WARPS);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(THREAD_N);
  localparam logic [CW-1:0] LAST_ROW = CW'(THREAD_N - 1);

  logic [DW-1:0]      mem_data_q [DEPTH];
  logic [NR_BITS-1:0] mem_rd_q   [DEPTH];
  logic [WW-1:0]      mem_wid_q  [DEPTH];
  logic               mem_wb_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [CW-1:0] row_cnt_q [NUM_WARPS];
  logic [CW-1:0] row_cnt_d [NUM_WARPS];
  logic          td_valid_q, td_valid_d;
  logic [WW-1:0] td_wid_q, td_wid_d;

  logic          full_s, empty_s, bypass_s, push_s, pop_s, fifo_pop_s;
  logic [AW-1:0] head_s;

  // Queue status, head presentation and handshake qualification
  always_comb begin
    full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_s   = (wr_ptr_q == rd_ptr_q);
    head_s    = rd_ptr_q[AW-1:0];
    out_valid = !empty_s;
    out_data  = mem_data_q[head_s];
    out_rd    = mem_rd_q[head_s];
    out_wid   = mem_wid_q[head_s];
    out_wb    = mem_wb_q[head_s];
    bypass_s  = 1'b0;
`ifdef TENSOR_WBQ_BYPASS_EN
    // An empty queue forwards the incoming packet; it is only stored if not taken now
    if (empty_s) begin
      out_valid = in_valid;
      out_data  = in_data;
      out_rd    = in_rd;
      out_wid   = in_wid;
      out_wb    = in_wb;
      bypass_s  = in_valid && out_ready;
    end else begin
      bypass_s  = 1'b0;
    end
`endif
    out_last   = (row_cnt_q[out_wid] == LAST_ROW);
    in_ready   = !full_s;
    pop_s      = out_valid && out_ready;
    push_s     = in_valid && !full_s && !bypass_s;
    fifo_pop_s = pop_s && !bypass_s;
  end

  // Next-state for pointers, occupancy, row counters and tile-done pulse
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (fifo_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, fifo_pop_s})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (pop_s && (out_wid == WW'(w))) begin
        row_cnt_d[w] = out_last ? '0 : row_cnt_q[w] + CW'(1);
      end else begin
        row_cnt_d[w] = row_cnt_q[w];
      end
    end
    td_valid_d = pop_s && out_last;
    if (td_valid_d) begin
      td_wid_d = out_wid;
    end else begin
      td_wid_d = td_wid_q;
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      td_valid_q <= 1'b0;
      td_wid_q   <= '0;
      for (int w = 0; w < NUM_WARPS; w++) row_cnt_q[w] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      td_valid_q <= td_valid_d;
      td_wid_q   <= td_wid_d;
      for (int w = 0; w < NUM_WARPS; w++) row_cnt_q[w] <= row_cnt_d[w];
    end
  end

  // Packet storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= in_data;
      mem_rd_q[wr_ptr_q[AW-1:0]]   <= in_rd;
      mem_wid_q[wr_ptr_q[AW-1:0]]  <= in_wid;
      mem_wb_q[wr_ptr_q[AW-1:0]]   <= in_wb;
    end
  end

  assign occupancy       = occ_q;
  assign tile_done_valid = td_valid_q;
  assign tile_done_wid   = td_wid_q;

endmodule

// File: tb/tb_tensor_wb_queue.sv
// Self-checking bench for tensor_wb_queue: directed table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_tensor_wb_queue;
  localparam int NT = 4, XL = 32, NW = 8, TN = 4, DP = 4, NRB = 5;
  localparam int DW = NT * XL, WW = $clog2(NW), OW = $clog2(DP + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_wb, out_valid, out_ready, out_wb, out_last, tile_done_valid;
  logic [DW-1:0]  in_data, out_data;
  logic [NRB-1:0] in_rd, out_rd;
  logic [WW-1:0]  in_wid, out_wid, tile_done_wid;
  logic [OW-1:0]  occupancy;

  always #5 clk = ~clk;

  tensor_wb_queue #(.NUM_THREADS(NT), .XLEN(XL), .NUM_WARPS(NW), .THREAD_N(TN),
                    .DEPTH(DP), .NR_BITS(NRB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .in_wid(in_wid), .in_wb(in_wb),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_wid(out_wid), .out_wb(out_wb), .out_last(out_last),
    .tile_done_valid(tile_done_valid), .tile_done_wid(tile_done_wid), .occupancy(occupancy)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [NRB-1:0] rd;
    logic [WW-1:0]  wid;
    logic           wb;
  } pkt_t;

  typedef struct {
    logic iv; int wid;
    int exp_ov; int exp_occ; int exp_last; int exp_wid; int exp_tdv; int exp_tdw;
  } vec_t;

  // Reference model: a queue of packets plus total pops per warp
  pkt_t mq[$];
  int   pops[NW];
  bit   exp_tdv;
  int   exp_tdw;
  int   n_chk = 0, n_fail = 0;
  bit   byp_en;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input int w, input int r);
    pkt_t p;
    p.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    p.rd   = NRB'(r);
    p.wid  = WW'(w);
    p.wb   = 1'($urandom_range(0, 1));
    return p;
  endfunction

  function automatic pkt_t cur_in();
    pkt_t p;
    p.data = in_data; p.rd = in_rd; p.wid = in_wid; p.wb = in_wb;
    return p;
  endfunction

  // Which packet the consumer should see now, if any
  function automatic bit model_head(output pkt_t h);
    h = cur_in();
    if (mq.size() > 0) begin
      h = mq[0];
      return 1'b1;
    end
    return byp_en && in_valid;
  endfunction

  task automatic model_reset();
    mq.delete();
    foreach (pops[w]) pops[w] = 0;
    exp_tdv = 1'b0;
    exp_tdw = 0;
  endtask

  task automatic drive(input logic iv, input pkt_t p, input logic ordy);
    in_valid = iv; in_data = p.data; in_rd = p.rd; in_wid = p.wid; in_wb = p.wb;
    out_ready = ordy;
  endtask

  task automatic check_model();
    pkt_t h;
    bit   hv;
    hv = model_head(h);
    chk("in_ready", DW'(in_ready), DW'(mq.size() < DP));
    chk("out_valid", DW'(out_valid), DW'(hv));
    chk("occupancy", DW'(occupancy), DW'(mq.size()));
    chk("tile_done_valid", DW'(tile_done_valid), DW'(exp_tdv));
    if (exp_tdv) chk("tile_done_wid", DW'(tile_done_wid), DW'(exp_tdw));
    if (hv) begin
      chk("out_data", out_data, h.data);
      chk("out_rd", DW'(out_rd), DW'(h.rd));
      chk("out_wid", DW'(out_wid), DW'(h.wid));
      chk("out_wb", DW'(out_wb), DW'(h.wb));
      chk("out_last", DW'(out_last), DW'((pops[h.wid] % TN) == TN - 1));
    end
  endtask

  // Called just after the clock edge while the inputs of that cycle are still applied
  task automatic update_model();
    pkt_t h;
    bit   hv, pop, byp_pop, push;
    hv      = model_head(h);
    pop     = hv && out_ready;
    byp_pop = pop && (mq.size() == 0);
    push    = in_valid && (mq.size() < DP) && !byp_pop;
    exp_tdv = pop && ((pops[h.wid] % TN) == TN - 1);
    if (exp_tdv) exp_tdw = int'(h.wid);
    if (pop) begin
      pops[h.wid]++;
      if (!byp_pop) void'(mq.pop_front());
    end
    if (push) mq.push_back(cur_in());
  endtask

  task automatic step(input logic iv, input pkt_t p, input logic ordy);
    drive(iv, p, ordy);
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  vec_t tv[10];
  pkt_t p, held;

  initial begin
    byp_en = 1'b0;
`ifdef TENSOR_WBQ_BYPASS_EN
    byp_en = 1'b1;
`endif
    // Interleaved tile table: 4 rows of warp 2 with 3 rows of warp 5, consumer always ready
    tv[0] = '{1'b1, 2, 0, 0, 0, 0, 0, 0};
    tv[1] = '{1'b1, 5, 1, 1, 0, 2, 0, 0};
    tv[2] = '{1'b1, 2, 1, 1, 0, 5, 0, 0};
    tv[3] = '{1'b1, 5, 1, 1, 0, 2, 0, 0};
    tv[4] = '{1'b1, 2, 1, 1, 0, 5, 0, 0};
    tv[5] = '{1'b1, 5, 1, 1, 0, 2, 0, 0};
    tv[6] = '{1'b1, 2, 1, 1, 0, 5, 0, 0};
    tv[7] = '{1'b0, 0, 1, 1, 1, 2, 0, 0};
    tv[8] = '{1'b0, 0, 0, 0, 0, 0, 1, 2};
    tv[9] = '{1'b0, 0, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    drive(1'b0, mk(0, 0), 1'b0);
    model_reset();
    #12;
    chk("rst in_ready", DW'(in_ready), DW'(1));
    chk("rst out_valid", DW'(out_valid), DW'(0));
    chk("rst occupancy", DW'(occupancy), DW'(0));
    chk("rst tile_done_valid", DW'(tile_done_valid), DW'(0));
    chk("rst tile_done_wid", DW'(tile_done_wid), DW'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    if (!byp_en) begin
      for (int i = 0; i < 10; i++) begin
        drive(tv[i].iv, mk(tv[i].wid, i), 1'b1);
        @(negedge clk);
        chk("tbl out_valid", DW'(out_valid), DW'(tv[i].exp_ov));
        chk("tbl occupancy", DW'(occupancy), DW'(tv[i].exp_occ));
        chk("tbl tile_done_valid", DW'(tile_done_valid), DW'(tv[i].exp_tdv));
        if (tv[i].exp_ov != 0) begin
          chk("tbl out_wid", DW'(out_wid), DW'(tv[i].exp_wid));
          chk("tbl out_last", DW'(out_last), DW'(tv[i].exp_last));
        end
        if (tv[i].exp_tdv != 0) chk("tbl tile_done_wid", DW'(tile_done_wid), DW'(tv[i].exp_tdw));
        check_model();
        @(posedge clk); update_model(); #1;
      end
    end

    // Single push with 0xA5 per lane
    p.data = {4{32'h0000_00A5}}; p.rd = 5'd7; p.wid = 3'd3; p.wb = 1'b1;
    step(1'b1, p, 1'b1);
    step(1'b0, p, 1'b1);
    step(1'b0, p, 1'b1);

    // Fill to full with a 5th packet held, then drain
    for (int i = 0; i < 4; i++) step(1'b1, mk(6, i), 1'b0);
    held = mk(6, 4);
    step(1'b1, held, 1'b0);
    chk("full in_ready", DW'(in_ready), DW'(0));
    step(1'b1, held, 1'b1);
    chk("post-pop in_ready", DW'(in_ready), DW'(1));
    step(1'b1, held, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, held, 1'b1);

    // Sustained push/pop at occupancy 2
    step(1'b1, mk(7, 0), 1'b0);
    step(1'b1, mk(7, 1), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, mk(int'($urandom_range(0, NW - 1)), i), 1'b1);
    chk("steady occupancy", DW'(occupancy), DW'(2));
    for (int i = 0; i < 3; i++) step(1'b0, held, 1'b1);

    // Mid-stream reset with warp 1 at row 2 and three entries held
    model_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, mk(1, 0), 1'b1);
    step(1'b1, mk(1, 1), 1'b1);
    step(1'b0, held, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, mk(4, i), 1'b0);
    drive(1'b0, held, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", DW'(in_ready), DW'(1));
    chk("mid rst out_valid", DW'(out_valid), DW'(0));
    chk("mid rst occupancy", DW'(occupancy), DW'(0));
    chk("mid rst tile_done_valid", DW'(tile_done_valid), DW'(0));
    chk("mid rst tile_done_wid", DW'(tile_done_wid), DW'(0));
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step(1'b1, mk(1, i), 1'b1);
    step(1'b0, held, 1'b1);
    step(1'b0, held, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), mk(int'($urandom_range(0, NW - 1)), i),
           1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 6; i++) step(1'b0, held, 1'b1);

`ifdef TENSOR_WBQ_BYPASS_EN
    drive(1'b1, mk(0, 9), 1'b1);
    @(negedge clk);
    chk("bypass out_valid", DW'(out_valid), DW'(1));
    chk("bypass occupancy", DW'(occupancy), DW'(0));
    check_model();
    @(posedge clk); update_model(); #1;
    step(1'b0, held, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tensor_wb_queue.md
# tensor_wb_queue

Result writeback queue directly downstream of the tensor core. It accepts one result packet per cycle: all lanes of one tensor-core output row, plus destination register, warp ID and writeback target. It buffers packets in a DEPTH-entry FIFO and presents them in order to the commit/writeback arbiter over a valid/ready handshake. It also tracks per-warp row counts, marks the last row of each THREAD_N-row tile, and pulses a tile-completion event used to release the warp's tensor scoreboard entry.

## Interface
Parameters:
- NUM_THREADS, 4: lanes per packet
- XLEN, 32: bits per lane
- NUM_WARPS, 8: warps tracked; power of two, ≥2
- THREAD_N, 4: rows per tile; ≥2
- DEPTH, 4: FIFO entries; power of two, ≥2
- NR_BITS, 5: register index width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  packet offered by the tensor core
- in_ready  out  1  queue can accept
- in_data  in  NUM_THREADS*XLEN  lane results; lane 0 in LSBs
- in_rd  in  NR_BITS  destination register or tile-buffer index
- in_wid  in  $clog2(NUM_WARPS)  warp ID
- in_wb  in  1  1 = architectural register, 0 = internal tile buffer
- out_valid  out  1  head packet valid
- out_ready  in  1  consumer accepts
- out_data / out_rd / out_wid / out_wb  out  as inputs  head packet fields
- out_last  out  1  head packet is the THREAD_N-th row of its warp's tile
- tile_done_valid  out  1  one-cycle tile-completion pulse
- tile_done_wid  out  $clog2(NUM_WARPS)  warp whose tile completed
- occupancy  out  $clog2(DEPTH+1)  entries held

## Operation
- FIFO storage:
  - Circular buffer of DEPTH entries; write and read pointers are $clog2(DEPTH)+1 bits (extra wrap bit).
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
- Handshake:
  - Push on in_valid && in_ready. Pop on out_valid && out_ready.
  - in_ready = !full, registered-state only. A full queue does not accept a push in the same cycle as a pop; in_ready rises the cycle after the pop.
- Simultaneous push and pop on a non-empty, non-full queue: both occur; occupancy is unchanged.
- Outputs:
  - out_valid = !empty.
  - out_data, out_rd, out_wid, out_wb come from the head slot.
  - The bench checks them only when out_valid = 1.
- Per-warp tile tracking:
  - row_cnt[w] counts 0..THREAD_N-1.
  - out_last = (row_cnt[out_wid] == THREAD_N-1).
  - On pop, row_cnt[out_wid] increments; it wraps to 0 when out_last = 1.
  - Packets of both in_wb values are counted.
- Tile completion:
  - A pop with out_last = 1 sets tile_done_valid = 1 and tile_done_wid = out_wid in the following cycle, for exactly one cycle.
  - Back-to-back last pops give back-to-back pulses.
- Interleaving: packets of different warps may interleave arbitrarily. Counters are independent per warp.
- Reset values, mid-operation reset included:
  - in_ready = 1, out_valid = 0, occupancy = 0, tile_done_valid = 0, tile_done_wid = 0.
  - All row_cnt = 0; pointers = 0.
  - FIFO contents are not reset and are discarded.
  - Reset is asynchronous assert; deassertion is synchronised outside the block.

## Timing
- Latency without the macro: a packet pushed in cycle N is visible at the outputs (out_valid = 1) in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- Full-queue stall: one bubble on the input after full (no pass-through when full).
- tile_done_valid: registered, asserted one cycle after the qualifying pop.
- occupancy: registered; updates the cycle after a push or pop.
- No combinational path from in_* to out_* without the macro; out_ready does not affect in_ready combinationally.

## Configuration
- TENSOR_WBQ_BYPASS_EN defined, when the queue is empty:
  - out_valid = in_valid, and out_* fields are driven combinationally from in_*.
  - out_last uses row_cnt[in_wid].
  - If out_ready = 1, the packet is consumed without being written (zero latency; occupancy stays 0).
  - If out_ready = 0, it is written normally.
  - tile_done timing is unchanged (the cycle after the pop).
- TENSOR_WBQ_BYPASS_EN undefined: the 1-cycle latency path only; out_* depend on registered state alone.

## Test plan
- Reset then single push (wid=3, rd=7, in_wb=1, data=0xA5 per lane), out_ready=1 → out_valid in the next cycle with matching fields; out_last=0; occupancy returns to 0.
- DEPTH=4, out_ready=0, push 5 packets → in_ready=0 after the 4th push; 5th held; occupancy=4. Set out_ready=1 → pops in order; in_ready=1 the cycle after the first pop.
- THREAD_N=4 rows for wid=2 interleaved with 3 rows for wid=5 → out_last only on the 4th wid=2 pop; tile_done_valid=1, tile_done_wid=2 one cycle later; no pulse for wid=5.
- Continuous push/pop at occupancy 2 for 20 cycles → occupancy stays 2; data order preserved; pointer wrap exercised.
- Assert rst_n=0 mid-stream with 3 entries held and row_cnt[1]=2 → outputs immediately take their reset values; after release, a fresh 4-row tile for wid=1 gives out_last on its 4th row.
- TENSOR_WBQ_BYPASS_EN defined, empty queue, in_valid=out_ready=1 → out_valid in the same cycle; occupancy stays 0.
